// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control FSM for the non-pipelined RV32 core. Each instruction
//   is stepped through FETCH, DECODE, EXEC, MEM and WB according to the opcode
//   of the instruction register. Illegal opcodes and memory timeouts send the
//   FSM to an absorbing TRAP state. Only reset leaves TRAP.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   opcode            opcode field of the instruction register
//   branchTaken       ALU branch condition, used in EXEC
//   imemReady         instruction memory data valid
//   dmemReady         data memory access complete
//   imemReq, irWrite  fetch request / instruction register load
//   dmemReq, dmemWe   data memory request / write enable
//   regWrite          register file write enable
//   memToReg          write-back source (1 = memory, 0 = ALU/link)
//   pcWrite, pcSrc    PC update strobe / select (0 = pc+4, 1 = pc+imm)
//   retire            one-cycle pulse per completed instruction
//   instCount         retired instruction count (wraps)
//   trap, trapCause   sticky error flag and cause
//                     (1 illegal, 2 imem timeout, 3 dmem timeout)
//   state             current FSM state, for debug
module multicycle_sequencer #(
  parameter logic [6:0]  INST_R        = 7'b0110011,
  parameter logic [6:0]  INST_I_LD     = 7'b0000011,
  parameter logic [6:0]  INST_I_IMM    = 7'b0010011,
  parameter logic [6:0]  INST_S        = 7'b0100011,
  parameter logic [6:0]  INST_B        = 7'b1100011,
  parameter logic [6:0]  INST_J        = 7'b1101111,
  parameter int unsigned WORD_BITWIDTH = 32,
  parameter int unsigned MEM_TIMEOUT   = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [6:0]               opcode,
  input  logic                     branchTaken,
  input  logic                     imemReady,
  input  logic                     dmemReady,
  output logic                     imemReq,
  output logic                     irWrite,
  output logic                     dmemReq,
  output logic                     dmemWe,
  output logic                     regWrite,
  output logic                     memToReg,
  output logic                     pcWrite,
  output logic                     pcSrc,
  output logic                     retire,
  output logic [WORD_BITWIDTH-1:0] instCount,
  output logic                     trap,
  output logic [1:0]               trapCause,
  output logic [2:0]               state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_e;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_e                   state_q, state_d;
  logic [7:0]               wait_q, wait_d;
  logic [WORD_BITWIDTH-1:0] count_q, count_d;
  logic                     trap_q, trap_d;
  logic [1:0]               cause_q, cause_d;
  logic                     legal;

  assign legal = (opcode == INST_R) || (opcode == INST_I_LD) ||
                 (opcode == INST_I_IMM) || (opcode == INST_S) ||
                 (opcode == INST_B) || (opcode == INST_J);

  always_comb begin
    imemReq  = 1'b0;
    irWrite  = 1'b0;
    dmemReq  = 1'b0;
    dmemWe   = 1'b0;
    regWrite = 1'b0;
    memToReg = 1'b0;
    pcWrite  = 1'b0;
    pcSrc    = 1'b0;
    retire   = 1'b0;
    state_d  = state_q;
    wait_d   = wait_q;
    trap_d   = trap_q;
    cause_d  = cause_q;

    unique case (state_q)
      FETCH: begin
        imemReq = 1'b1;
        if (imemReady) begin
          irWrite = 1'b1;
          wait_d  = '0;
          state_d = DECODE;
        end else if (wait_q == TIMEOUT) begin
          wait_d  = '0;
          trap_d  = 1'b1;
          cause_d = 2'd2;
          state_d = TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DECODE: begin
        wait_d = '0;
        if (legal) begin
          state_d = EXEC;
        end else begin
          trap_d  = 1'b1;
          cause_d = 2'd1;
          state_d = TRAP;
        end
      end
      EXEC: begin
        wait_d = '0;
        if (opcode == INST_B) begin
          pcWrite = 1'b1;
          pcSrc   = branchTaken;
          retire  = 1'b1;
          state_d = FETCH;
        end else if (opcode == INST_I_LD || opcode == INST_S) begin
          state_d = MEM;
        end else if (opcode == INST_R || opcode == INST_I_IMM ||
                     opcode == INST_J) begin
          state_d = WB;
        end else begin
          // opcode changed after DECODE; treat as illegal rather than guess
          trap_d  = 1'b1;
          cause_d = 2'd1;
          state_d = TRAP;
        end
      end
      MEM: begin
        dmemReq = 1'b1;
        dmemWe  = (opcode == INST_S);
        if (dmemReady) begin
          wait_d = '0;
          if (opcode == INST_S) begin
            pcWrite = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (wait_q == TIMEOUT) begin
          wait_d  = '0;
          trap_d  = 1'b1;
          cause_d = 2'd3;
          state_d = TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      WB: begin
        regWrite = 1'b1;
        memToReg = (opcode == INST_I_LD);
        pcWrite  = 1'b1;
        pcSrc    = (opcode == INST_J);
        retire   = 1'b1;
        state_d  = FETCH;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        wait_d  = '0;
        state_d = FETCH;
      end
    endcase

    // reset overrides every strobe so nothing is written on the reset cycle
    if (!rst_n) begin
      imemReq  = 1'b0;
      irWrite  = 1'b0;
      dmemReq  = 1'b0;
      dmemWe   = 1'b0;
      regWrite = 1'b0;
      memToReg = 1'b0;
      pcWrite  = 1'b0;
      pcSrc    = 1'b0;
      retire   = 1'b0;
      state_d  = FETCH;
      wait_d   = '0;
      trap_d   = 1'b0;
      cause_d  = 2'd0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (!rst_n) count_d = '0;
    else if (retire) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    wait_q  <= wait_d;
    count_q <= count_d;
    trap_q  <= trap_d;
    cause_q <= cause_d;
  end

  assign instCount = count_q;
  assign trap      = trap_q;
  assign trapCause = cause_q;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_J   = 7'b1101111;
  localparam int         TMO    = 15;

  logic        clk = 1'b0;
  logic        rst_n, branchTaken, imemReady, dmemReady;
  logic [6:0]  opcode;
  logic        imemReq, irWrite, dmemReq, dmemWe, regWrite, memToReg;
  logic        pcWrite, pcSrc, retire, trap;
  logic [31:0] instCount;
  logic [1:0]  trapCause;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_sequencer #(.WORD_BITWIDTH(32), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branchTaken(branchTaken),
    .imemReady(imemReady), .dmemReady(dmemReady), .imemReq(imemReq),
    .irWrite(irWrite), .dmemReq(dmemReq), .dmemWe(dmemWe),
    .regWrite(regWrite), .memToReg(memToReg), .pcWrite(pcWrite),
    .pcSrc(pcSrc), .retire(retire), .instCount(instCount), .trap(trap),
    .trapCause(trapCause), .state(state)
  );

  // One row per clock cycle: inputs to apply and outputs the spec demands.
  typedef struct {
    string      tag;
    bit         rstn, imr, dmr, bt;
    logic [6:0] op;
    bit         imemReq, irWrite, dmemReq, dmemWe, regWrite, memToReg;
    bit         pcWrite, pcSrc, retire, trap;
    logic [1:0] cause;
    logic [2:0] st;
  } row_t;

  row_t  q[$];
  string cur_tag;

  function automatic row_t blank(logic [6:0] op, bit bt, logic [2:0] st);
    row_t r;
    r.tag = cur_tag; r.rstn = 1'b1; r.imr = 1'b0; r.dmr = 1'b0; r.bt = bt;
    r.op = op; r.imemReq = 0; r.irWrite = 0; r.dmemReq = 0; r.dmemWe = 0;
    r.regWrite = 0; r.memToReg = 0; r.pcWrite = 0; r.pcSrc = 0;
    r.retire = 0; r.trap = 0; r.cause = 2'd0; r.st = st;
    return r;
  endfunction

  function automatic logic [14:0] pk(row_t r);
    return {r.imemReq, r.irWrite, r.dmemReq, r.dmemWe, r.regWrite, r.memToReg,
            r.pcWrite, r.pcSrc, r.retire, r.trap, r.cause, r.st};
  endfunction

  function automatic bit is_legal(logic [6:0] op);
    return op inside {OP_R, OP_LD, OP_IMM, OP_S, OP_B, OP_J};
  endfunction

  // Whole-instruction expectation: iw/dw are the cycles the memory keeps
  // ready low; more than TMO of them ends in a timeout.
  task automatic add_instr(input logic [6:0] op, input bit bt, input int iw,
                           input int dw, input bit abort_mem);
    row_t r;
    for (int k = 0; k < iw && k <= TMO; k++) begin
      r = blank(op, bt, 3'd0); r.imemReq = 1; q.push_back(r);
    end
    if (iw > TMO) return;
    r = blank(op, bt, 3'd0); r.imr = 1; r.imemReq = 1; r.irWrite = 1;
    q.push_back(r);
    r = blank(op, bt, 3'd1); q.push_back(r);
    if (!is_legal(op)) return;
    r = blank(op, bt, 3'd2);
    if (op == OP_B) begin
      r.pcWrite = 1; r.pcSrc = bt; r.retire = 1; q.push_back(r);
      return;
    end
    q.push_back(r);
    if (op == OP_LD || op == OP_S) begin
      for (int k = 0; k < dw && k <= TMO; k++) begin
        r = blank(op, bt, 3'd3); r.dmemReq = 1; r.dmemWe = (op == OP_S);
        q.push_back(r);
      end
      if (dw > TMO || abort_mem) return;
      r = blank(op, bt, 3'd3); r.dmr = 1; r.dmemReq = 1;
      r.dmemWe = (op == OP_S);
      if (op == OP_S) begin
        r.pcWrite = 1; r.retire = 1; q.push_back(r);
        return;
      end
      q.push_back(r);
    end
    r = blank(op, bt, 3'd4); r.regWrite = 1; r.memToReg = (op == OP_LD);
    r.pcWrite = 1; r.pcSrc = (op == OP_J); r.retire = 1; q.push_back(r);
  endtask

  task automatic add_trap(input int n, input logic [1:0] cause,
                          input logic [6:0] op);
    row_t r;
    for (int k = 0; k < n; k++) begin
      r = blank(op, 1'b0, 3'd7); r.imr = 1; r.dmr = 1; r.trap = 1;
      r.cause = cause; q.push_back(r);
    end
  endtask

  // Reset cycle: registered outputs still show the pre-reset values.
  task automatic add_reset(input logic [2:0] st, input bit tr,
                           input logic [1:0] cause, input logic [6:0] op);
    row_t r;
    r = blank(op, 1'b0, st); r.rstn = 0; r.imr = 1; r.dmr = 1;
    r.trap = tr; r.cause = cause; q.push_back(r);
  endtask

  task automatic pin(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: model gives %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic lat(input string name, input logic [6:0] op, input bit bt,
                     input int iw, input int dw, input int want);
    int n0;
    cur_tag = name;
    n0 = q.size();
    add_instr(op, bt, iw, dw, 1'b0);
    pin(name, q.size() - n0, want);
  endtask

  initial begin
    int   model_cnt;
    row_t r;

    // test 1: reset then R-type, then latency pins for the other opcodes
    cur_tag = "reset";  add_reset(3'd0, 0, 2'd0, OP_R);
    lat("lat_R", OP_R, 0, 0, 0, 4);
    lat("lat_IMM", OP_IMM, 0, 0, 0, 4);
    lat("lat_J", OP_J, 0, 0, 0, 4);
    lat("lat_S", OP_S, 0, 0, 0, 4);
    lat("lat_LD", OP_LD, 0, 0, 0, 5);
    // test 2: load with dmemReady delayed 3 cycles
    lat("ld_wait3", OP_LD, 0, 0, 3, 8);
    // test 3: taken / not-taken branch
    lat("br_taken", OP_B, 1, 0, 0, 3);
    lat("br_not", OP_B, 0, 0, 0, 3);
    lat("R_iwait2", OP_R, 0, 2, 0, 6);
    lat("S_dwait1", OP_S, 0, 0, 1, 5);
    // test 4: illegal opcodes
    cur_tag = "illegal7F";
    add_instr(7'h7F, 0, 0, 0, 0); add_trap(3, 2'd1, 7'h7F);
    add_reset(3'd7, 1, 2'd1, 7'h7F);
    cur_tag = "illegal00";
    add_instr(7'h00, 0, 0, 0, 0); add_trap(2, 2'd1, 7'h00);
    add_reset(3'd7, 1, 2'd1, 7'h00);
    lat("after_trap", OP_IMM, 0, 0, 0, 4);
    // test 5: imem timeout, then ready on the last permitted cycle
    lat("imem_tmo", OP_R, 0, 20, 0, 16);
    add_trap(2, 2'd2, OP_R); add_reset(3'd7, 1, 2'd2, OP_R);
    lat("imem_edge", OP_R, 0, 15, 0, 19);
    lat("dmem_tmo", OP_LD, 0, 0, 20, 19);
    add_trap(2, 2'd3, OP_LD); add_reset(3'd7, 1, 2'd3, OP_LD);
    lat("dmem_edge", OP_LD, 0, 0, 15, 20);
    // test 6: reset while a store sits in MEM
    cur_tag = "st_abort";
    add_instr(OP_S, 0, 0, 1, 1); add_reset(3'd3, 0, 2'd0, OP_S);
    lat("post_abort", OP_J, 0, 0, 0, 4);

    // drive and compare cycle by cycle
    rst_n = 0; imemReady = 0; dmemReady = 0; branchTaken = 0; opcode = OP_R;
    repeat (2) @(posedge clk);
    model_cnt = 0;
    foreach (q[i]) begin
      r = q[i];
      #1;
      rst_n = r.rstn; imemReady = r.imr; dmemReady = r.dmr;
      branchTaken = r.bt; opcode = r.op;
      @(negedge clk);
      checks++;
      if ({imemReq, irWrite, dmemReq, dmemWe, regWrite, memToReg, pcWrite,
           pcSrc, retire, trap, trapCause, state} !== pk(r)) begin
        errors++;
        $display("FAIL %s row %0d: got strobes/trap/cause/state %b, expected %b",
                 r.tag, i, {imemReq, irWrite, dmemReq, dmemWe, regWrite,
                 memToReg, pcWrite, pcSrc, retire, trap, trapCause, state},
                 pk(r));
      end
      checks++;
      if (instCount !== 32'(model_cnt)) begin
        errors++;
        $display("FAIL %s row %0d instCount: got %0d, expected %0d",
                 r.tag, i, instCount, model_cnt);
      end
      if (!r.rstn) model_cnt = 0;
      else if (r.retire) model_cnt++;
      @(posedge clk);
    end
    #1;
    checks++;
    if (instCount !== 32'd1) begin
      errors++;
      $display("FAIL final_count: got %0d, expected 1", instCount);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
